// File: rtl/cholesky_pkg.sv
// Cholesky schedule controller: shared state encoding,
// default latencies and a constant-width helper.
package cholesky_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIAG_ISSUE,
    S_DIAG_WAIT,
    S_LOWER_ISSUE,
    S_LOWER_WAIT,
    S_SETTLE,
    S_DONE
  } state_e;

  localparam int DIAG_LAT_DEF  = 22;
  localparam int LOWER_LAT_DEF = 24;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/cholesky_lane_mask.sv
// Lane-enable mask and group column base for pivot row j, group g;
// captured on issue and held through the following wait.
module cholesky_lane_mask
  import cholesky_pkg::*;
#(
  parameter int LANES = 4,
  parameter int DIM_W = 4,
  parameter int GRP_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             clr_i,
  input  logic [DIM_W-1:0] n_i,
  input  logic [DIM_W-1:0] row_i,
  input  logic [GRP_W-1:0] grp_i,
  output logic [LANES-1:0] lane_en_o,
  output logic [DIM_W-1:0] col_base_o
);

  int               base;
  logic [LANES-1:0] mask_d;
  logic [DIM_W-1:0] col_base_d;
  logic [LANES-1:0] lane_en_q;
  logic [DIM_W-1:0] col_base_q;

  always_comb begin
    base       = int'(row_i) + 1 + int'(grp_i) * LANES;
    col_base_d = DIM_W'(base);
    mask_d     = '0;
    for (int k = 0; k < LANES; k++)
      mask_d[k] = (base + k) < int'(n_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_en_q  <= '0;
      col_base_q <= '0;
    end else if (load_i) begin
      lane_en_q  <= mask_d;
      col_base_q <= col_base_d;
    end else if (clr_i) begin
      lane_en_q  <= '0;
      col_base_q <= '0;
    end
  end

  assign lane_en_o  = lane_en_q;
  assign col_base_o = col_base_q;

endmodule

// File: rtl/cholesky_sched_ctrl.sv
// Row-by-row Cholesky schedule: one sqrt per pivot row, then
// below-diagonal elements in groups of LANES, with stall and handshake.
module cholesky_sched_ctrl
  import cholesky_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int DIM_W     = 4,
  parameter int DIAG_LAT  = DIAG_LAT_DEF,
  parameter int LOWER_LAT = LOWER_LAT_DEF,
  parameter int MAX_N     = 15
) (
  input  logic             clock,
  input  logic             areset_n,
  input  logic             start,
  input  logic [DIM_W-1:0] matrix_size,
  input  logic             stall,
  output logic             busy,
  output logic             done,
  output logic             size_err,
  output logic             clear,
  output logic             diag_issue,
  output logic             lower_issue,
  output logic [LANES-1:0] lane_en,
  output logic [DIM_W-1:0] row,
  output logic [DIM_W-1:0] col_base,
  output logic             first_row,
  output logic [LANES:0]   clock_en
);

  localparam int MAX_LAT = (DIAG_LAT > LOWER_LAT) ? DIAG_LAT : LOWER_LAT;
  localparam int CNT_W   = clog2(MAX_LAT + 1);
  localparam int GRP_W   = clog2((MAX_N + LANES - 1) / LANES + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIM_W-1:0] row_q, row_d;
  logic [DIM_W-1:0] n_q, n_d;
  logic [GRP_W-1:0] grp_q, grp_d;
  logic             size_err_q, size_err_d;

  logic legal, last_row, more_grp, settle, row_end;
  logic lane_load, lane_clr;

  assign legal    = (matrix_size != '0) && (int'(matrix_size) <= MAX_N);
  assign last_row = (int'(row_q) + 1) == int'(n_q);
  assign more_grp = (int'(row_q) + 1 + (int'(grp_q) + 1) * LANES) < int'(n_q);
  assign settle   = ((int'(row_q) + 1) % LANES) == 0;

  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      row_q      <= '0;
      n_q        <= '0;
      grp_q      <= '0;
      size_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      row_q      <= row_d;
      n_q        <= n_d;
      grp_q      <= grp_d;
      size_err_q <= size_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    row_d      = row_q;
    n_d        = n_q;
    grp_d      = grp_q;
    size_err_d = 1'b0;
    row_end    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (legal) begin
            n_d     = matrix_size;
            row_d   = '0;
            grp_d   = '0;
            state_d = S_DIAG_ISSUE;
          end else begin
            size_err_d = 1'b1;
          end
        end
      end
      S_DIAG_ISSUE: begin
        if (!stall) begin
          cnt_d   = CNT_W'(DIAG_LAT - 1);
          state_d = S_DIAG_WAIT;
        end
      end
      S_DIAG_WAIT: begin
        if (!stall) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (!last_row) begin
            grp_d   = '0;
            state_d = S_LOWER_ISSUE;
          end else begin
            row_end = 1'b1;
          end
        end
      end
      S_LOWER_ISSUE: begin
        if (!stall) begin
          cnt_d   = CNT_W'(LOWER_LAT - 1);
          state_d = S_LOWER_WAIT;
        end
      end
      S_LOWER_WAIT: begin
        if (!stall) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (more_grp) begin
            grp_d   = grp_q + GRP_W'(1);
            state_d = S_LOWER_ISSUE;
          end else begin
            row_end = 1'b1;
          end
        end
      end
      S_SETTLE: begin
        if (!stall) state_d = S_DIAG_ISSUE;
      end
      S_DONE: begin
        if (!stall) begin
          row_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A bubble follows every LANES-th row so the lane pipes drain.
    if (row_end) begin
      if (last_row) begin
        state_d = S_DONE;
      end else begin
        row_d   = row_q + DIM_W'(1);
        state_d = settle ? S_SETTLE : S_DIAG_ISSUE;
      end
    end
  end

  assign lane_load = state_d == S_LOWER_ISSUE;
  assign lane_clr  = (state_d != S_LOWER_ISSUE) && (state_d != S_LOWER_WAIT);

  cholesky_lane_mask #(
    .LANES (LANES),
    .DIM_W (DIM_W),
    .GRP_W (GRP_W)
  ) u_mask (
    .clk        (clock),
    .rst_n      (areset_n),
    .load_i     (lane_load),
    .clr_i      (lane_clr),
    .n_i        (n_q),
    .row_i      (row_d),
    .grp_i      (grp_d),
    .lane_en_o  (lane_en),
    .col_base_o (col_base)
  );

  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign clear       = state_q == S_IDLE;
  assign done        = (state_q == S_DONE) && !stall;
  assign size_err    = size_err_q;
  assign diag_issue  = (state_q == S_DIAG_ISSUE) && !stall;
  assign lower_issue = (state_q == S_LOWER_ISSUE) && !stall;
  assign row         = row_q;
  assign first_row   = row_q == '0;
  assign clock_en    = {lane_en, busy || clear};

endmodule

// File: tb/tb_cholesky_sched_ctrl.sv
// Bench for cholesky_sched_ctrl: phase-list model of the schedule,
// checked every cycle, plus literal pins from hand-derived timings.
module tb_cholesky_sched_ctrl;

  localparam int LANES = 4;
  localparam int DIM_W = 4;
  localparam int DLAT  = 22;
  localparam int LLAT  = 24;
  localparam int MAXN  = 12;

  localparam int K_IDLE = 0;
  localparam int K_DI   = 1;
  localparam int K_DW   = 2;
  localparam int K_LI   = 3;
  localparam int K_LW   = 4;
  localparam int K_SET  = 5;
  localparam int K_DONE = 6;

  logic             clock = 1'b0;
  logic             areset_n = 1'b0;
  logic             start = 1'b0;
  logic             stall = 1'b0;
  logic [DIM_W-1:0] matrix_size = '0;
  logic             busy, done, size_err, clear;
  logic             diag_issue, lower_issue, first_row;
  logic [LANES-1:0] lane_en;
  logic [DIM_W-1:0] row, col_base;
  logic [LANES:0]   clock_en;

  always #5 clock = ~clock;

  cholesky_sched_ctrl #(
    .LANES     (LANES),
    .DIM_W     (DIM_W),
    .DIAG_LAT  (DLAT),
    .LOWER_LAT (LLAT),
    .MAX_N     (MAXN)
  ) dut (
    .clock       (clock),
    .areset_n    (areset_n),
    .start       (start),
    .matrix_size (matrix_size),
    .stall       (stall),
    .busy        (busy),
    .done        (done),
    .size_err    (size_err),
    .clear       (clear),
    .diag_issue  (diag_issue),
    .lower_issue (lower_issue),
    .lane_en     (lane_en),
    .row         (row),
    .col_base    (col_base),
    .first_row   (first_row),
    .clock_en    (clock_en)
  );

  typedef struct {
    int kind;
    int row;
    int cb;
    int mask;
  } ph_t;

  ph_t q[$];
  int  li_mask[$];
  int  li_cb[$];
  int  nvec = 0;
  int  nerr = 0;
  int  cyc = 0;
  bit  se_pend = 1'b0;
  int  busy_n = 0, di_n = 0, li_n = 0, done_n = 0, se_n = 0;
  int  start_cyc = 0, done_cyc = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  // Every cycle of one decomposition, in order, as the schedule rules give it.
  task automatic expand(input int n);
    ph_t p;
    for (int j = 0; j < n; j++) begin
      p = '{K_DI, j, 0, 0};
      q.push_back(p);
      p.kind = K_DW;
      repeat (DLAT) q.push_back(p);
      for (int cb = j + 1; cb < n; cb += LANES) begin
        int m;
        m = 0;
        for (int k = 0; k < LANES; k++)
          if (cb + k < n) m |= (1 << k);
        p = '{K_LI, j, cb, m};
        q.push_back(p);
        p.kind = K_LW;
        repeat (LLAT) q.push_back(p);
      end
      if (j == n - 1) begin
        p = '{K_DONE, j, 0, 0};
        q.push_back(p);
      end else if ((j + 1) % LANES == 0) begin
        p = '{K_SET, j, 0, 0};
        q.push_back(p);
      end
    end
  endtask

  task automatic tick();
    ph_t h;
    bit  idle, lw;
    int  ek, em;
    @(negedge clock);
    cyc++;
    if (!areset_n) begin
      q.delete();
      se_pend = 1'b0;
    end
    idle = q.size() == 0;
    if (idle) h = '{K_IDLE, 0, 0, 0};
    else h = q[0];
    ek = h.kind;
    lw = (ek == K_LI) || (ek == K_LW);
    em = lw ? h.mask : 0;
    chk("busy", int'(busy), int'(!idle && ek != K_DONE));
    chk("done", int'(done), int'(ek == K_DONE && !stall));
    chk("size_err", int'(size_err), int'(se_pend));
    chk("clear", int'(clear), int'(idle));
    chk("diag_issue", int'(diag_issue), int'(ek == K_DI && !stall));
    chk("lower_issue", int'(lower_issue), int'(ek == K_LI && !stall));
    chk("lane_en", int'(lane_en), em);
    chk("clock_en", int'(clock_en), (em << 1) | int'(ek != K_DONE));
    if (ek == K_DI || ek == K_DW || lw) begin
      chk("row", int'(row), h.row);
      chk("first_row", int'(first_row), int'(h.row == 0));
    end
    if (lw) chk("col_base", int'(col_base), h.cb);
    if (!areset_n) begin
      chk("rst_row", int'(row), 0);
      chk("rst_col_base", int'(col_base), 0);
      chk("rst_first_row", int'(first_row), 1);
    end
    busy_n += int'(busy);
    if (diag_issue) di_n++;
    if (lower_issue) begin
      li_n++;
      li_mask.push_back(int'(lane_en));
      li_cb.push_back(int'(col_base));
    end
    if (done) begin
      done_n++;
      done_cyc = cyc;
    end
    if (size_err) se_n++;
    se_pend = 1'b0;
    if (areset_n) begin
      if (idle) begin
        if (start) begin
          if (matrix_size != 0 && int'(matrix_size) <= MAXN) begin
            expand(int'(matrix_size));
            start_cyc = cyc;
          end else begin
            se_pend = 1'b1;
          end
        end
      end else if (!stall) begin
        void'(q.pop_front());
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic wait_done(input int budget);
    int  d0;
    bit  ok;
    d0 = done_n;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (done_n != d0) ok = 1'b1;
    end
    chk("done_timeout", int'(ok), 1);
  endtask

  task automatic kick(input int n);
    matrix_size = DIM_W'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  int b0, d0, l0, s0, dn0;

  initial begin
    tick();
    chk("rst_clock_en", int'(clock_en), 1);
    chk("rst_clear", int'(clear), 1);
    tick();
    areset_n = 1'b1;
    tick();

    b0 = busy_n; d0 = di_n; l0 = li_n;
    kick(1);
    wait_done(100);
    chk("n1_busy", busy_n - b0, 23);
    chk("n1_diag", di_n - d0, 1);
    chk("n1_lower", li_n - l0, 0);
    chk("n1_done_at", done_cyc - start_cyc, 24);

    b0 = busy_n; d0 = di_n; l0 = li_n;
    li_mask.delete(); li_cb.delete();
    kick(4);
    wait_done(400);
    chk("n4_busy", busy_n - b0, 167);
    chk("n4_diag", di_n - d0, 4);
    chk("n4_lower", li_n - l0, 3);
    chk("n4_done_at", done_cyc - start_cyc, 168);
    if (li_mask.size() == 3) begin
      chk("n4_mask0", li_mask[0], 4'b0111);
      chk("n4_mask1", li_mask[1], 4'b0011);
      chk("n4_mask2", li_mask[2], 4'b0001);
    end else begin
      chk("n4_mask_count", li_mask.size(), 3);
    end

    b0 = busy_n; d0 = di_n; l0 = li_n;
    li_mask.delete(); li_cb.delete();
    kick(6);
    wait_done(600);
    chk("n6_busy", busy_n - b0, 289);
    chk("n6_diag", di_n - d0, 6);
    chk("n6_lower", li_n - l0, 6);
    chk("n6_done_at", done_cyc - start_cyc, 290);
    if (li_mask.size() >= 2) begin
      chk("n6_mask0", li_mask[0], 4'b1111);
      chk("n6_cb0", li_cb[0], 1);
      chk("n6_mask1", li_mask[1], 4'b0001);
      chk("n6_cb1", li_cb[1], 5);
    end else begin
      chk("n6_mask_count", li_mask.size(), 6);
    end

    // Five stall cycles inside row 2's sqrt wait, one on its lower issue.
    b0 = busy_n; d0 = di_n; l0 = li_n;
    li_cb.delete(); li_mask.delete();
    kick(6);
    repeat (129) tick();
    stall = 1'b1;
    repeat (5) tick();
    stall = 1'b0;
    repeat (15) tick();
    stall = 1'b1;
    tick();
    stall = 1'b0;
    wait_done(600);
    chk("stall_busy", busy_n - b0, 295);
    chk("stall_diag", di_n - d0, 6);
    chk("stall_lower", li_n - l0, 6);
    chk("stall_done_at", done_cyc - start_cyc, 296);
    if (li_cb.size() >= 4) chk("stall_row2_cb", li_cb[3], 3);

    b0 = busy_n; d0 = di_n; s0 = se_n;
    kick(0);
    tick();
    tick();
    chk("n0_size_err", se_n - s0, 1);
    kick(MAXN + 1);
    tick();
    tick();
    chk("nbig_size_err", se_n - s0, 2);
    kick(15);
    tick();
    chk("n15_size_err", se_n - s0, 3);
    chk("bad_busy", busy_n - b0, 0);
    chk("bad_diag", di_n - d0, 0);

    kick(6);
    repeat (29) tick();
    dn0 = done_n;
    areset_n = 1'b0;
    #1;
    chk("amid_busy", int'(busy), 0);
    chk("amid_clear", int'(clear), 1);
    chk("amid_lane_en", int'(lane_en), 0);
    chk("amid_clock_en", int'(clock_en), 1);
    chk("amid_row", int'(row), 0);
    tick();
    tick();
    areset_n = 1'b1;
    tick();
    chk("amid_no_done", done_n - dn0, 0);
    b0 = busy_n;
    kick(4);
    wait_done(400);
    chk("post_rst_busy", busy_n - b0, 167);

    for (int i = 0; i < 6000; i++) begin
      start = $urandom_range(0, 19) == 0;
      matrix_size = DIM_W'($urandom_range(0, 15));
      stall = $urandom_range(0, 7) == 0;
      tick();
    end
    start = 1'b0;
    stall = 1'b0;
    repeat (700) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
